ahb_sram_subordinate: RTL and testbench

//  AHB-Lite SRAM subordinate. One instance per slot on the response mux's slave-side HRDATAn/HRESPn/HREADYn inputs.

---
 rtl/ahb_sram_subordinate.sv | 143 ++++++++++++++
 tb/tb_ahb_sram_subordinate.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/ahb_sram_subordinate.sv
// AHB-Lite SRAM subordinate: word array, byte-lane writes, WAIT_STATES wait cycles, two-cycle ERROR.
// Optional: define AHB_SRAM_SUB_RO_REGION_EN to make the top quarter of the array read-only.
module ahb_sram_subordinate #(
   parameter int unsigned ADDR_WIDTH  = 32,
   parameter int unsigned DATA_WIDTH  = 32,
   parameter int unsigned MEM_DEPTH   = 256,
   parameter int unsigned WAIT_STATES = 0
) (
   input  logic                  HCLK,
   input  logic                  HRESETn,
   input  logic                  HSEL,
   input  logic [ADDR_WIDTH-1:0] HADDR,
   input  logic [1:0]            HTRANS,
   input  logic                  HWRITE,
   input  logic [2:0]            HSIZE,
   input  logic [DATA_WIDTH-1:0] HWDATA,
   input  logic                  HREADY,
   output logic                  HREADYOUT,
   output logic [1:0]            HRESP,
   output logic [DATA_WIDTH-1:0] HRDATA
);
   localparam int unsigned BYTES = DATA_WIDTH / 8;
   localparam int unsigned LSB   = $clog2(BYTES);
   localparam int unsigned IDX_W = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;

   typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_ERR1, ST_ERR2} state_t;

   state_t                state, state_n;
   logic [3:0]            cnt, cnt_n;
   logic                  active, active_n;
   logic [IDX_W-1:0]      idx;
   logic [LSB-1:0]        lane;
   logic                  wr;
   logic [2:0]            size;
   logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];

   logic                  accept, illegal, final_ph, commit;
   logic [ADDR_WIDTH-1:0] word_addr, size_mask;
   logic [BYTES-1:0]      be;
   logic                  unused_bits;

   assign unused_bits = HTRANS[0];

   assign accept   = HSEL && HREADY && HTRANS[1] && (state == ST_IDLE || state == ST_ERR2);
   assign final_ph = (state == ST_IDLE) && active;
   assign commit   = final_ph && wr;

   always_comb begin
      word_addr = HADDR >> LSB;
      size_mask = (ADDR_WIDTH'(1) << HSIZE) - ADDR_WIDTH'(1);
      illegal   = (word_addr >= ADDR_WIDTH'(MEM_DEPTH)) || (HSIZE > 3'(LSB)) ||
                  ((HADDR & size_mask) != '0);
`ifdef AHB_SRAM_SUB_RO_REGION_EN
      if (HWRITE && (word_addr >= ADDR_WIDTH'(3 * MEM_DEPTH / 4)))
         illegal = 1'b1;
`endif
   end

   always_ff @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn) begin
         state  <= ST_IDLE;
         cnt    <= '0;
         active <= 1'b0;
         idx    <= '0;
         lane   <= '0;
         wr     <= 1'b0;
         size   <= '0;
      end else begin
         state  <= state_n;
         cnt    <= cnt_n;
         active <= active_n;
         if (accept) begin
            idx  <= HADDR[LSB +: IDX_W];
            lane <= HADDR[LSB-1:0];
            wr   <= HWRITE;
            size <= HSIZE;
         end
      end
   end

   // A legal transfer holds 'active' through WAIT; its final cycle is IDLE with active set.
   always_comb begin
      state_n   = state;
      cnt_n     = cnt;
      active_n  = active;
      HREADYOUT = 1'b1;
      HRESP     = 2'b00;
      case (state)
         ST_WAIT: begin
            HREADYOUT = 1'b0;
            cnt_n     = cnt - 4'd1;
            if (cnt <= 4'd1)
               state_n = ST_IDLE;
         end
         ST_ERR1: begin
            HREADYOUT = 1'b0;
            HRESP     = 2'b01;
            state_n   = ST_ERR2;
         end
         ST_ERR2: begin
            HRESP   = 2'b01;
            state_n = ST_IDLE;
         end
         default: ;
      endcase
      if (state == ST_IDLE || state == ST_ERR2) begin
         active_n = 1'b0;
         if (accept) begin
            if (illegal) begin
               state_n = ST_ERR1;
            end else begin
               active_n = 1'b1;
               if (WAIT_STATES > 0) begin
                  state_n = ST_WAIT;
                  cnt_n   = 4'(WAIT_STATES);
               end else begin
                  state_n = ST_IDLE;
               end
            end
         end
      end
   end

   always_comb begin
      be = '0;
      for (int unsigned i = 0; i < BYTES; i++)
         if (i >= 32'(lane) && i < 32'(lane) + (32'd1 << size))
            be[i] = 1'b1;
   end

   always_ff @(posedge HCLK) begin
      if (commit)
         for (int unsigned i = 0; i < BYTES; i++)
            if (be[i])
               mem[idx][8*i +: 8] <= HWDATA[8*i +: 8];
   end

   always_comb begin
      HRDATA = '0;
      if (final_ph && !wr)
         HRDATA = mem[idx];
   end
endmodule

// File: tb/tb_ahb_sram_subordinate.sv
// Scoreboard bench for ahb_sram_subordinate: instance 0 has no wait states, instance 1 has three.
module tb_ahb_sram_subordinate;
   localparam int DEPTH = 256;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        sel   [2];
   logic [31:0] addr  [2];
   logic [1:0]  trans [2];
   logic        write [2];
   logic [2:0]  size  [2];
   logic [31:0] wdata [2];
   logic        rdy   [2];
   logic [1:0]  resp  [2];
   logic [31:0] rdata [2];

   int checks = 0;
   int failures = 0;
   int issued [2] = '{0, 0};
   int done   [2] = '{0, 0};
   int wait_states [2] = '{0, 3};

   typedef struct {
      logic        is_read;
      logic [1:0]  resp;
      logic [31:0] rdata;
      int          lows;
   } exp_t;

   exp_t        sbq0 [$];
   exp_t        sbq1 [$];
   logic [31:0] model [2][DEPTH];

   always #5 clk = ~clk;

   ahb_sram_subordinate #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .MEM_DEPTH(DEPTH), .WAIT_STATES(0)) dut0 (
      .HCLK(clk), .HRESETn(rst_n), .HSEL(sel[0]), .HADDR(addr[0]), .HTRANS(trans[0]),
      .HWRITE(write[0]), .HSIZE(size[0]), .HWDATA(wdata[0]), .HREADY(rdy[0]),
      .HREADYOUT(rdy[0]), .HRESP(resp[0]), .HRDATA(rdata[0]));

   ahb_sram_subordinate #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .MEM_DEPTH(DEPTH), .WAIT_STATES(3)) dut3 (
      .HCLK(clk), .HRESETn(rst_n), .HSEL(sel[1]), .HADDR(addr[1]), .HTRANS(trans[1]),
      .HWRITE(write[1]), .HSIZE(size[1]), .HWDATA(wdata[1]), .HREADY(rdy[1]),
      .HREADYOUT(rdy[1]), .HRESP(resp[1]), .HRDATA(rdata[1]));

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%h expected=%h", tag, got, exp);
      end
   endtask

   // Drives one address phase, waits for acceptance, builds the expectation from the model.
   task automatic issue(input int d, input logic w, input logic [31:0] a, input logic [2:0] sz,
                        input logic [31:0] wd);
      exp_t e;
      int   n, nb, lo, word;
      logic legal;
      sel[d] = 1'b1; trans[d] = 2'b10; write[d] = w; addr[d] = a; size[d] = sz;
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!rdy[d] && n < 50);
      if (!rdy[d]) check("accept_timeout", 32'(rdy[d]), 32'd1);
      nb    = 1 << sz;
      lo    = int'(a & 32'd3);
      word  = int'(a >> 2);
      legal = (a < DEPTH * 4) && (sz <= 3'd2) && ((a % nb) == 0);
`ifdef AHB_SRAM_SUB_RO_REGION_EN
      if (w && word >= 3 * DEPTH / 4) legal = 1'b0;
`endif
      e.is_read = !w;
      e.resp    = legal ? 2'b00 : 2'b01;
      e.lows    = legal ? wait_states[d] : 1;
      e.rdata   = '0;
      if (legal) begin
         if (w) begin
            for (int b = 0; b < 4; b++)
               if (b >= lo && b < lo + nb) model[d][word][8*b +: 8] = wd[8*b +: 8];
         end else begin
            e.rdata = model[d][word];
         end
      end
      if (d == 0) sbq0.push_back(e); else sbq1.push_back(e);
      @(posedge clk);
      #1;
      issued[d]++;
      wdata[d] = wd;
      sel[d] = 1'b0; trans[d] = 2'b00;
   endtask

   task automatic drain();
      int n;
      n = 0;
      while ((issued[0] != done[0] || issued[1] != done[1]) && n < 100) begin
         @(negedge clk);
         n++;
      end
      if (issued[0] != done[0] || issued[1] != done[1])
         check("drain_timeout", 32'(done[0] + done[1]), 32'(issued[0] + issued[1]));
      @(negedge clk);
   endtask

   // Data-phase monitor: counts stalled cycles, then compares the final cycle against the queue head.
   int lows [2] = '{0, 0};
   always @(negedge clk) begin
      exp_t e;
      for (int d = 0; d < 2; d++) begin
         if (issued[d] > done[d]) begin
            e = (d == 0) ? sbq0[0] : sbq1[0];
            if (!rdy[d]) begin
               lows[d]++;
               check($sformatf("d%0d_stall_resp", d), 32'(resp[d]), 32'(e.resp));
               check($sformatf("d%0d_stall_rdata", d), rdata[d], 32'd0);
            end else begin
               if (d == 0) void'(sbq0.pop_front()); else void'(sbq1.pop_front());
               check($sformatf("d%0d_resp", d), 32'(resp[d]), 32'(e.resp));
               check($sformatf("d%0d_wait_cycles", d), 32'(lows[d]), 32'(e.lows));
               if (e.is_read || e.resp != 2'b00)
                  check($sformatf("d%0d_rdata", d), rdata[d], e.rdata);
               lows[d] = 0;
               done[d]++;
            end
         end
      end
   end

   initial begin
      int n;
      rst_n = 1'b0;
      for (int d = 0; d < 2; d++) begin
         sel[d] = 1'b0; addr[d] = '0; trans[d] = 2'b00; write[d] = 1'b0; size[d] = '0; wdata[d] = '0;
      end
      repeat (2) @(negedge clk);
      for (int d = 0; d < 2; d++) begin
         check("reset_hreadyout", 32'(rdy[d]), 32'd1);
         check("reset_hresp", 32'(resp[d]), 32'd0);
         check("reset_hrdata", rdata[d], 32'd0);
      end
      @(posedge clk); #1 rst_n = 1'b1;

      // back-to-back write then read, zero wait states
      issue(0, 1'b1, 32'h10, 3'd2, 32'hDEADBEEF);
      issue(0, 1'b0, 32'h10, 3'd2, 32'h0);
      // byte and halfword lanes
      issue(0, 1'b1, 32'h20, 3'd2, 32'h00000000);
      issue(0, 1'b1, 32'h22, 3'd0, 32'h00AB0000);
      issue(0, 1'b0, 32'h20, 3'd2, 32'h0);
      issue(0, 1'b1, 32'h24, 3'd2, 32'h11223344);
      issue(0, 1'b1, 32'h26, 3'd1, 32'hCAFE0000);
      issue(0, 1'b1, 32'h25, 3'd0, 32'h00007700);
      issue(0, 1'b0, 32'h24, 3'd2, 32'h0);
      // illegal transfers: unaligned, out of range, oversize, unaligned halfword write
      issue(0, 1'b0, 32'h01, 3'd2, 32'h0);
      issue(0, 1'b0, DEPTH * 4, 3'd2, 32'h0);
      issue(0, 1'b0, 32'h20, 3'd3, 32'h0);
      issue(0, 1'b1, 32'h21, 3'd1, 32'hFFFFFFFF);
      issue(0, 1'b0, 32'h20, 3'd2, 32'h0);
      // last word of the array
      issue(0, 1'b1, DEPTH * 4 - 4, 3'd2, 32'h5EED1234);
      issue(0, 1'b0, DEPTH * 4 - 4, 3'd2, 32'h0);
      // read-only boundary (ERROR pairs only when the region is enabled)
      issue(0, 1'b1, 32'd100 * 4, 3'd2, 32'h0BADF00D);
      issue(0, 1'b0, 32'd100 * 4, 3'd2, 32'h0);
      issue(0, 1'b1, 32'd191 * 4, 3'd2, 32'h19119100);
      issue(0, 1'b0, 32'd191 * 4, 3'd2, 32'h0);
      issue(0, 1'b1, 32'd200 * 4, 3'd2, 32'h20020000);
      issue(0, 1'b0, 32'd200 * 4, 3'd2, 32'h0);
      issue(0, 1'b1, 32'd192 * 4, 3'd2, 32'h19219200);
      issue(0, 1'b0, 32'd192 * 4, 3'd2, 32'h0);
      drain();

      // three wait states
      issue(1, 1'b1, 32'h10, 3'd2, 32'hA5A55A5A);
      issue(1, 1'b0, 32'h10, 3'd2, 32'h0);
      issue(1, 1'b0, 32'h01, 3'd2, 32'h0);
      issue(1, 1'b1, 32'h40, 3'd2, 32'h00000000);
      issue(1, 1'b0, 32'h40, 3'd2, 32'h0);
      drain();

      // reset in the middle of a write's wait states drops the write
      sel[1] = 1'b1; trans[1] = 2'b10; write[1] = 1'b1; addr[1] = 32'h40; size[1] = 3'd2;
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!rdy[1] && n < 50);
      @(posedge clk); #1;
      sel[1] = 1'b0; trans[1] = 2'b00; wdata[1] = 32'hBAD0BAD0;
      @(negedge clk);
      check("wait_before_reset", 32'(rdy[1]), 32'd0);
      rst_n = 1'b0;
      #1;
      check("midwait_reset_hreadyout", 32'(rdy[1]), 32'd1);
      check("midwait_reset_hresp", 32'(resp[1]), 32'd0);
      check("midwait_reset_hrdata", rdata[1], 32'd0);
      @(posedge clk); #1 rst_n = 1'b1;
      issue(1, 1'b0, 32'h40, 3'd2, 32'h0);
      issue(0, 1'b0, 32'h10, 3'd2, 32'h0);
      drain();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout got=running expected=finished");
      $fatal(1, "timeout");
   end
endmodule
